pcs_transmit: RTL

- 1000BASE-X PCS transmit path: the counterpart of the receive block. It converts GMII octets (TXD, TX_EN, TX_ER) into a stream of 10-bit code-groups, one per clock.
- Generates /I1/ and /I2/ idles, /S/, /T/, /R/ and /V/ ordered sets, keeps even/odd slot alignment, and tracks running disparity (RD).
- Output feeds the PMA serializer. Its {code-group, even} pair is the same shape the receive block consumes, so the two close a loopback.

---
 rtl/pcs_transmit_pkg.sv | 21 ++
 rtl/pcs_transmit_encode_8b10b.sv | 76 +++++++
 rtl/pcs_transmit.sv | 113 +++++++++++
 3 files changed

// File: rtl/pcs_transmit_pkg.sv
// Shared 8b/10b definitions for the 1000BASE-X PCS transmit path.
// Holds the 8b values of the ordered-set code-groups and the disparity helpers.
package pcs_transmit_pkg;

  localparam logic [7:0] K28_5  = 8'hBC;
  localparam logic [7:0] CODE_S = 8'hFB;  // K27.7
  localparam logic [7:0] CODE_T = 8'hFD;  // K29.7
  localparam logic [7:0] CODE_R = 8'hF7;  // K23.7
  localparam logic [7:0] CODE_V = 8'hFE;  // K30.7
  localparam logic [7:0] D5_6   = 8'hC5;
  localparam logic [7:0] D16_2  = 8'h50;

  function automatic logic unbalanced6(input logic [5:0] v);
    return $countones(v) != 3;
  endfunction

  function automatic logic unbalanced4(input logic [3:0] v);
    return $countones(v) != 2;
  endfunction

endpackage

// File: rtl/pcs_transmit_encode_8b10b.sv
// Combinational 8b/10b encoder: 5b/6b and 3b/4b tables stored in the RD- column,
// complemented for RD+ where the sub-block is unbalanced (or is D.7 / D.x.3 / any K.x.y).
module encode_8b10b
  import pcs_transmit_pkg::*;
(
  input  logic [7:0] data,
  input  logic       is_k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] b6, c6;
  logic [3:0] b4, c4;
  logic       rd_mid;
  logic       alt7;

  assign x = data[4:0];
  assign y = data[7:5];

  always_comb begin
    b6 = 6'b000000;
    case (x)
      5'd0:  b6 = 6'b100111;  5'd1:  b6 = 6'b011101;
      5'd2:  b6 = 6'b101101;  5'd3:  b6 = 6'b110001;
      5'd4:  b6 = 6'b110101;  5'd5:  b6 = 6'b101001;
      5'd6:  b6 = 6'b011001;  5'd7:  b6 = 6'b111000;
      5'd8:  b6 = 6'b111001;  5'd9:  b6 = 6'b100101;
      5'd10: b6 = 6'b010101;  5'd11: b6 = 6'b110100;
      5'd12: b6 = 6'b001101;  5'd13: b6 = 6'b101100;
      5'd14: b6 = 6'b011100;  5'd15: b6 = 6'b010111;
      5'd16: b6 = 6'b011011;  5'd17: b6 = 6'b100011;
      5'd18: b6 = 6'b010011;  5'd19: b6 = 6'b110010;
      5'd20: b6 = 6'b001011;  5'd21: b6 = 6'b101010;
      5'd22: b6 = 6'b011010;  5'd23: b6 = 6'b111010;
      5'd24: b6 = 6'b110011;  5'd25: b6 = 6'b100110;
      5'd26: b6 = 6'b010110;  5'd27: b6 = 6'b110110;
      5'd28: b6 = 6'b001110;  5'd29: b6 = 6'b101110;
      5'd30: b6 = 6'b011110;  default: b6 = 6'b101011;
    endcase
    if (is_k && x == 5'd28) b6 = 6'b001111;

    // D.7 is balanced but still alternates its form with RD
    c6     = (rd_in && (unbalanced6(b6) || (!is_k && x == 5'd7))) ? ~b6 : b6;
    rd_mid = unbalanced6(b6) ? ~rd_in : rd_in;

    // Alternate D.x.7 avoids a run of five identical bits across the sub-block boundary
    alt7 = is_k ||
           (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
           ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));

    b4 = 4'b0000;
    if (is_k) begin
      case (y)
        3'd0: b4 = 4'b1011;  3'd1: b4 = 4'b0110;
        3'd2: b4 = 4'b1010;  3'd3: b4 = 4'b1100;
        3'd4: b4 = 4'b1101;  3'd5: b4 = 4'b0101;
        3'd6: b4 = 4'b1001;  default: b4 = 4'b0111;
      endcase
    end else begin
      case (y)
        3'd0: b4 = 4'b1011;  3'd1: b4 = 4'b1001;
        3'd2: b4 = 4'b0101;  3'd3: b4 = 4'b1100;
        3'd4: b4 = 4'b1101;  3'd5: b4 = 4'b1010;
        3'd6: b4 = 4'b0110;  default: b4 = alt7 ? 4'b0111 : 4'b1110;
      endcase
    end

    c4     = (rd_mid && (is_k || y == 3'd0 || y == 3'd3 || y == 3'd4 || y == 3'd7)) ? ~b4 : b4;
    rd_out = unbalanced4(b4) ? ~rd_mid : rd_mid;
    code   = {c6, c4};
  end

endmodule

// File: rtl/pcs_transmit.sv
// 1000BASE-X PCS transmit: GMII octets to 10-bit code-groups with idles,
// /S/ /T/ /R/ /V/ ordered sets, even/odd slot alignment and running disparity.
module pcs_transmit
  import pcs_transmit_pkg::*;
#(
  parameter logic INIT_RD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TXD,
  input  logic       TX_EN,
  input  logic       TX_ER,
  output logic [9:0] tx_code_group,
  output logic       tx_even,
  output logic       transmitting
);

  typedef enum logic [4:0] {
    IDLE_K = 5'b00001,
    IDLE_D = 5'b00010,
    DATA   = 5'b00100,
    EOP_R1 = 5'b01000,
    EOP_R2 = 5'b10000
  } state_t;

  state_t     state, next_state;
  logic       rd, rd_before, even_slot;
  logic [7:0] enc_data;
  logic       enc_k, next_tx, latch_rd_before;
  logic [9:0] enc_code;
  logic       enc_rd;

  encode_8b10b u_enc (
    .data   (enc_data),
    .is_k   (enc_k),
    .rd_in  (rd),
    .code   (enc_code),
    .rd_out (enc_rd)
  );

  always_comb begin
    next_state      = IDLE_K;
    enc_data        = K28_5;
    enc_k           = 1'b1;
    next_tx         = 1'b0;
    latch_rd_before = 1'b0;
    case (state)
      IDLE_K: begin
        if (TX_EN) begin
          enc_data   = CODE_S;
          next_tx    = 1'b1;
          next_state = DATA;
        end else begin
          latch_rd_before = 1'b1;
          next_state      = IDLE_D;
        end
      end
      // /I1/ restores negative disparity when K28.5 was sent from RD+
      IDLE_D: begin
        enc_data   = rd_before ? D5_6 : D16_2;
        enc_k      = 1'b0;
        next_state = IDLE_K;
      end
      DATA: begin
        if (TX_EN && !TX_ER) begin
          enc_data   = TXD;
          enc_k      = 1'b0;
          next_tx    = 1'b1;
          next_state = DATA;
        end else if (TX_EN) begin
          enc_data   = CODE_V;
          next_tx    = 1'b1;
          next_state = DATA;
        end else begin
          enc_data   = CODE_T;
          next_state = EOP_R1;
        end
      end
      EOP_R1: begin
        enc_data   = CODE_R;
        next_state = even_slot ? EOP_R2 : IDLE_K;
      end
      EOP_R2: begin
        enc_data   = CODE_R;
        next_state = IDLE_K;
      end
      default: begin
        next_state = IDLE_K;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE_K;
      rd            <= INIT_RD;
      rd_before     <= 1'b0;
      even_slot     <= 1'b1;
      tx_code_group <= 10'b0;
      tx_even       <= 1'b0;
      transmitting  <= 1'b0;
    end else begin
      state         <= next_state;
      rd            <= enc_rd;
      even_slot     <= ~even_slot;
      tx_code_group <= enc_code;
      tx_even       <= even_slot;
      transmitting  <= next_tx;
      if (latch_rd_before) rd_before <= rd;
    end
  end

endmodule
